// File: rtl/adder64_serial_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder64_serial_ctrl_pkg
// Description : Shared state encoding and default widths for the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package adder64_serial_ctrl_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_SLICE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : adder64_serial_ctrl_pkg
`default_nettype wire

// File: rtl/full_adder_8_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_8_bit
// Description : Combinational ripple-carry slice adder, SLICE bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_8_bit #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_carry,
    output logic [SLICE-1:0] o_sum,
    output logic             o_carry
);

    logic w_ripple;

    always_comb begin
        w_ripple = i_carry;
        o_sum    = '0;
        for (int i = 0; i < SLICE; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_ripple;
            w_ripple = (i_a[i] & i_b[i]) | (w_ripple & (i_a[i] ^ i_b[i]));
        end
        o_carry = w_ripple;
    end

endmodule : full_adder_8_bit
`default_nettype wire

// File: rtl/adder64_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder64_serial_ctrl
// Description : WIDTH-bit adder built from one SLICE-bit slice reused NSLICE
//               cycles, with valid/ready handshakes on operands and result.
// Revision    : 1.0 - initial release
// ============================================================================
module adder64_serial_ctrl
    import adder64_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] c_last_slice = CNT_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;

    logic [SLICE-1:0]   w_slice_a;
    logic [SLICE-1:0]   w_slice_b;
    logic [SLICE-1:0]   w_slice_sum;
    logic               w_slice_carry;
    logic               w_accept;
    logic               w_last;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_last    = (r_state == ST_RUN) && (r_cnt == c_last_slice);
    assign w_slice_a = r_op_a[int'(r_cnt)*SLICE +: SLICE];
    assign w_slice_b = r_op_b[int'(r_cnt)*SLICE +: SLICE];

    full_adder_8_bit #(
        .SLICE   (SLICE)
    ) u_slice (
        .i_a     (w_slice_a),
        .i_b     (w_slice_b),
        .i_carry (r_carry),
        .o_sum   (w_slice_sum),
        .o_carry (w_slice_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Each RUN cycle retires one slice, low slices first, carry chained through r_carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= A;
            r_op_b  <= B;
            r_carry <= carry_in;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum[int'(r_cnt)*SLICE +: SLICE] <= w_slice_sum;
            r_carry <= w_slice_carry;
            if (w_last) begin
                r_cnt       <= '0;
                r_carry_out <= w_slice_carry;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule : adder64_serial_ctrl
`default_nettype wire

// File: doc/adder64_serial_ctrl.md
Name: adder64_serial_ctrl

Overview:
- Sequencer that performs a 64-bit add using one 8-bit ripple slice, reused over 8 clock cycles. This trades latency for area against the fully unrolled 64-bit adder.
- Operands are accepted on a valid/ready input handshake. The result is returned on a valid/ready output handshake.
- Intended as the area-optimised add engine in front of datapaths that do not need single-cycle sums.

Parameters:
- WIDTH, 64, total operand width; must be a multiple of SLICE.
- SLICE, 8, bits added per cycle by the slice adder.
- NSLICE, WIDTH/SLICE (=8), derived local constant; number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and carry_in presented.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- out_valid  output  1  sum/carry_out valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- carry_out  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, slice counter=0, carry register=0.
  - Operand registers=0, sum=0, carry_out=0, out_valid=0, busy=0.
  - in_ready=1 once reset deasserts.
- States: IDLE, RUN, DONE. The state is registered; in_ready, out_valid and busy are decoded from it.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch A, B and carry_in (into the carry register); clear sum; counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice adds opA[k*SLICE+:SLICE] + opB[same] + carry register, where k=counter.
  - Write the slice sum into sum[k*SLICE+:SLICE]. The carry register takes the slice carry. counter++.
  - When k==NSLICE-1, after that cycle's writes: carry_out takes the final slice carry and the state goes to DONE.
- DONE:
  - out_valid=1. sum and carry_out are stable.
  - On out_ready: go to IDLE and drop out_valid the next cycle.
  - out_valid stays high, with values held, until out_ready is seen.
- Latency: accept edge at cycle 0, then 8 RUN cycles. out_valid is first high in cycle 9 after the accepting edge. Throughput is 1 op per (NSLICE+2) cycles with out_ready held high.
- Ignored inputs:
  - in_valid during RUN/DONE is ignored; inputs are not sampled.
  - out_ready outside DONE is ignored.
- No back-to-back overlap: a new accept is possible only in IDLE, i.e. the cycle after the DONE handshake.
- sum is visible while in RUN: partially written, low slices first. Consumers use it only when out_valid=1.
- Arithmetic: unsigned modulo 2^WIDTH, with carry_out as bit WIDTH. The result must equal {carry_out,sum} = A+B+carry_in.
- Counter width is clog2(NSLICE). It never wraps inside RUN, because the exit happens at NSLICE-1.
- Reset mid-operation, in RUN or DONE:
  - Immediate return to IDLE and all reset values, including out_valid=0.
  - The in-flight result is discarded; there is no partial output.
- Simultaneous in_valid and reset: reset wins; nothing is latched.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH/SLICE constants.
- One sub-module: full_adder_8_bit (the existing 8-bit ripple slice), instantiated once with SLICE=8.
- The controller contains the FSM, counter, operand/carry registers, sum write-back and handshake logic.

Test Plan:
- Basic add: A=64'h0000_0000_0000_0005, B=64'h3, cin=0, out_ready=1 -> out_valid exactly 9 cycles after accept; sum=64'h8, carry_out=0; in_ready back high 1 cycle later.
- Full carry ripple: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> sum=0, carry_out=1. Checks the carry crossing all 8 slice boundaries.
- Backpressure: A=64'h8000_0000_0000_0000, B=64'h8000_0000_0000_0000, out_ready=0 for 5 cycles after out_valid -> out_valid, sum=0 and carry_out=1 held stable; in_valid pulses in DONE do not change state; release out_ready -> IDLE.
- Ignored input: during RUN present in_valid=1 with A=B=all-ones -> in_ready=0 and the result still equals the first operands. Then back-to-back ops 1+1 and 2+2 give 2 and 4, with an accept spacing of 10 cycles.
- Reset mid-op: assert reset at RUN counter=4 -> same cycle, out_valid=0, sum=0, busy=0. After release: in_ready=1; the next op 7+9 gives 16.
- Random: 1000 random A/B/cin with random out_ready stalls -> every {carry_out,sum} matches the reference A+B+cin; no result lost or duplicated.
